// File: rtl/ram_access_controller.sv
// ram_access_controller
//
// Drives the address, data and write-enable pins of a 32 x 4 RAM from slow,
// asynchronous front-panel controls. The controller has three modes:
//   - manual: address and data follow the switches
//   - write:  one write pulse for each press of key_write
//   - scan:   the address steps through 0..31 so the RAM contents can be read
// With MEM_CLEAR_EN defined, a press of key_clear writes zero to all 32 words.
//
// Optional feature macro: MEM_CLEAR_EN (adds the CLEAR state and the key_clear path).
//
// Parameters:
//   SCAN_DIV     clock cycles per scan address step (2 .. 2^26-1)
//   SYNC_STAGES  flop depth of each input synchronizer (>= 2)
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   reset      asynchronous, active-high reset
//   sw_addr    manual address switches (async)
//   sw_data    manual write-data switches (async)
//   key_write  write pushbutton, active high (async)
//   key_clear  clear pushbutton, active high (async); ignored without MEM_CLEAR_EN
//   scan_mode  1 = auto-scan read, 0 = manual (async level)
//   address    registered RAM address
//   data       registered RAM write data
//   wren       registered RAM write enable
//   busy       registered; high while a clear sequence runs
module ram_access_controller #(
   parameter int unsigned SCAN_DIV    = 50000000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] sw_addr,
   input  logic [3:0] sw_data,
   input  logic       key_write,
   input  logic       key_clear,
   input  logic       scan_mode,
   output logic [4:0] address,
   output logic [3:0] data,
   output logic       wren,
   output logic       busy
);

   localparam int unsigned DivW = 26;

   // Bundled async inputs: [4:0] addr, [8:5] data, [9] write, [10] scan, [11] clear.
`ifdef MEM_CLEAR_EN
   localparam int unsigned InW = 12;
`else
   localparam int unsigned InW = 11;
`endif

   typedef enum logic [1:0] {
`ifdef MEM_CLEAR_EN
      StClear,
`endif
      StIdle,
      StWrite,
      StScan
   } state_e;

   logic [InW-1:0]         in_raw;
   logic [InW-1:0]         sync_q [SYNC_STAGES];
   logic [InW-1:0]         sync_last;
   logic [SYNC_STAGES-1:0] valid_q;
   logic                   sync_valid;

   logic [4:0]             addr_sync;
   logic [3:0]             data_sync;
   logic                   wr_sync;
   logic                   scan_sync;

   logic                   wr_prev_q;
   logic                   wr_armed_q;
   logic                   wr_edge;

   state_e                 state_q;
   logic [4:0]             address_q;
   logic [3:0]             data_q;
   logic                   wren_q;
   logic                   busy_q;
   logic [DivW-1:0]        div_q;

`ifdef MEM_CLEAR_EN
   logic                   clr_sync;
   logic                   clr_prev_q;
   logic                   clr_armed_q;
   logic                   clr_edge;
   logic [4:0]             clr_cnt_q;

   assign in_raw = {key_clear, scan_mode, key_write, sw_data, sw_addr};
`else
   logic                   unused_key_clear;

   assign unused_key_clear = key_clear;
   assign in_raw = {scan_mode, key_write, sw_data, sw_addr};
`endif

   // Input synchronizers. valid_q marks when the last stage holds a real
   // post-reset sample rather than the reset zeros still draining out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         sync_q[0] <= in_raw;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_last  = sync_q[SYNC_STAGES-1];
   assign sync_valid = valid_q[SYNC_STAGES-1];
   assign addr_sync  = sync_last[4:0];
   assign data_sync  = sync_last[8:5];
   assign wr_sync    = sync_last[9];
   assign scan_sync  = sync_last[10];

   // Rising-edge detect. The armed flag needs a genuine low sample first, so
   // a key held down through reset release does not count as a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_prev_q  <= 1'b0;
         wr_armed_q <= 1'b0;
      end else begin
         wr_prev_q <= wr_sync;
         if (sync_valid && !wr_sync) begin
            wr_armed_q <= 1'b1;
         end
      end
   end

   assign wr_edge = wr_sync & ~wr_prev_q & wr_armed_q;

`ifdef MEM_CLEAR_EN
   assign clr_sync = sync_last[11];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clr_prev_q  <= 1'b0;
         clr_armed_q <= 1'b0;
      end else begin
         clr_prev_q <= clr_sync;
         if (sync_valid && !clr_sync) begin
            clr_armed_q <= 1'b1;
         end
      end
   end

   assign clr_edge = clr_sync & ~clr_prev_q & clr_armed_q;
`endif

   // Main FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         address_q <= '0;
         data_q    <= '0;
         wren_q    <= 1'b0;
         busy_q    <= 1'b0;
         div_q     <= '0;
`ifdef MEM_CLEAR_EN
         clr_cnt_q <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
`ifdef MEM_CLEAR_EN
               if (clr_edge) begin
                  state_q   <= StClear;
                  address_q <= '0;
                  data_q    <= '0;
                  wren_q    <= 1'b1;
                  busy_q    <= 1'b1;
                  clr_cnt_q <= '0;
               end else
`endif
               if (wr_edge) begin
                  state_q   <= StWrite;
                  address_q <= addr_sync;
                  data_q    <= data_sync;
                  wren_q    <= 1'b1;
               end else if (scan_sync) begin
                  state_q   <= StScan;
                  address_q <= '0;
                  div_q     <= '0;
                  wren_q    <= 1'b0;
               end else begin
                  address_q <= addr_sync;
                  data_q    <= data_sync;
                  wren_q    <= 1'b0;
               end
            end

            // Single write cycle; a pending scan request takes over right after.
            StWrite: begin
               wren_q <= 1'b0;
               if (scan_sync) begin
                  state_q   <= StScan;
                  address_q <= '0;
                  div_q     <= '0;
               end else begin
                  state_q   <= StIdle;
                  address_q <= addr_sync;
                  data_q    <= data_sync;
               end
            end

            // Write presses are deliberately dropped here, not queued.
            StScan: begin
               wren_q <= 1'b0;
`ifdef MEM_CLEAR_EN
               if (clr_edge) begin
                  state_q   <= StClear;
                  address_q <= '0;
                  data_q    <= '0;
                  wren_q    <= 1'b1;
                  busy_q    <= 1'b1;
                  clr_cnt_q <= '0;
               end else
`endif
               if (!scan_sync) begin
                  state_q   <= StIdle;
                  address_q <= addr_sync;
                  data_q    <= data_sync;
               end else if (div_q == DivW'(SCAN_DIV - 1)) begin
                  div_q     <= '0;
                  address_q <= address_q + 5'd1;
               end else begin
                  div_q <= div_q + DivW'(1);
               end
            end

`ifdef MEM_CLEAR_EN
            // All inputs are ignored until every word has been zeroed.
            StClear: begin
               if (clr_cnt_q == 5'd31) begin
                  state_q   <= StIdle;
                  wren_q    <= 1'b0;
                  busy_q    <= 1'b0;
                  address_q <= addr_sync;
                  data_q    <= data_sync;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 5'd1;
                  address_q <= clr_cnt_q + 5'd1;
               end
            end
`endif

            default: begin
               state_q <= StIdle;
               wren_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign address = address_q;
   assign data    = data_q;
   assign wren    = wren_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_ram_access_controller.sv
// Testbench for ram_access_controller (SYNC_STAGES=2, SCAN_DIV=4).
// A history-based reference model predicts the outputs after every clock edge
// and a compare process checks them on each falling edge; directed scenarios
// add literal checks at key moments. Clear scenarios need MEM_CLEAR_EN.
module tb_ram_access_controller;

   localparam int SS = 2;
   localparam int SD = 4;

   localparam int MIdle  = 0;
   localparam int MWrite = 1;
   localparam int MScan  = 2;
   localparam int MClear = 3;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic [4:0] sw_addr   = '0;
   logic [3:0] sw_data   = '0;
   logic       key_write = 1'b0;
   logic       key_clear = 1'b0;
   logic       scan_mode = 1'b0;
   logic [4:0] address;
   logic [3:0] data;
   logic       wren;
   logic       busy;

   ram_access_controller #(
      .SCAN_DIV    (SD),
      .SYNC_STAGES (SS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_addr   (sw_addr),
      .sw_data   (sw_data),
      .key_write (key_write),
      .key_clear (key_clear),
      .scan_mode (scan_mode),
      .address   (address),
      .data      (data),
      .wren      (wren),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_pass      = 0;
   int n_total     = 0;
   int wren_cycles = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [4:0] a;
      logic [3:0] d;
      logic       w;
      logic       c;
      logic       s;
   } smp_t;

   smp_t       hist[$];
   int         mode   = MIdle;
   int         start  = 0;
   int         n_edge = 0;
   logic [4:0] exp_addr = '0;
   logic [3:0] exp_data = '0;
   logic       exp_wren = 1'b0;
   logic       exp_busy = 1'b0;

   task automatic model_reset();
      hist.delete();
      mode     = MIdle;
      n_edge   = 0;
      exp_addr = '0;
      exp_data = '0;
      exp_wren = 1'b0;
      exp_busy = 1'b0;
   endtask

   task automatic go_scan();
      mode     = MScan;
      start    = n_edge;
      exp_addr = '0;
   endtask

   task automatic go_clear();
      mode     = MClear;
      start    = n_edge;
      exp_addr = '0;
      exp_data = '0;
      exp_wren = 1'b1;
      exp_busy = 1'b1;
   endtask

   // The controller acts on the input sample taken SS edges earlier; a press
   // is a real low sample followed by a high sample.
   task automatic model_step();
      smp_t cur, s, p;
      logic wr_edge, clr_edge;
      int   k;
      cur.a = sw_addr;
      cur.d = sw_data;
      cur.w = key_write;
      cur.c = key_clear;
      cur.s = scan_mode;
      hist.push_front(cur);
      if (hist.size() > SS + 2) void'(hist.pop_back());
      n_edge++;
      s        = '0;
      p        = '0;
      wr_edge  = 1'b0;
      clr_edge = 1'b0;
      if (hist.size() > SS) s = hist[SS];
      if (hist.size() > SS + 1) begin
         p        = hist[SS+1];
         wr_edge  = s.w && !p.w;
         clr_edge = s.c && !p.c;
      end
`ifndef MEM_CLEAR_EN
      clr_edge = 1'b0;
`endif
      exp_wren = 1'b0;
      exp_busy = 1'b0;
      case (mode)
         MIdle: begin
            if (clr_edge) go_clear();
            else if (wr_edge) begin
               mode     = MWrite;
               exp_addr = s.a;
               exp_data = s.d;
               exp_wren = 1'b1;
            end else if (s.s) go_scan();
            else begin
               exp_addr = s.a;
               exp_data = s.d;
            end
         end
         MWrite: begin
            if (s.s) go_scan();
            else begin
               mode     = MIdle;
               exp_addr = s.a;
               exp_data = s.d;
            end
         end
         MScan: begin
            if (clr_edge) go_clear();
            else if (!s.s) begin
               mode     = MIdle;
               exp_addr = s.a;
               exp_data = s.d;
            end else exp_addr = 5'(((n_edge - start) / SD) % 32);
         end
         default: begin
            k = n_edge - start;
            if (k >= 32) begin
               mode     = MIdle;
               exp_addr = s.a;
               exp_data = s.d;
            end else begin
               exp_addr = 5'(k);
               exp_data = '0;
               exp_wren = 1'b1;
               exp_busy = 1'b1;
            end
         end
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   // Compare process: every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         check("m_addr", 32'(address), 32'(exp_addr));
         check("m_data", 32'(data), 32'(exp_data));
         check("m_wren", 32'(wren), 32'(exp_wren));
         check("m_busy", 32'(busy), 32'(exp_busy));
         if (wren) wren_cycles++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int wc;

   initial begin
      step(3);
      reset = 1'b0;
      step(1);
      check("rst_addr", 32'(address), 32'h0);
      check("rst_wren", 32'(wren), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);

      // Single press: wren on the third edge after the first high sample.
      sw_addr = 5'h13;
      sw_data = 4'hA;
      step(4);
      wc = wren_cycles;
      key_write = 1'b1;
      step(2);
      check("w_lat_e2", 32'(wren), 32'h0);
      step(1);
      check("w_lat_e3", 32'(wren), 32'h1);
      check("w_addr", 32'(address), 32'h13);
      check("w_data", 32'(data), 32'hA);
      key_write = 1'b0;
      step(1);
      check("w_e4", 32'(wren), 32'h0);
      step(3);
      check("w_count", 32'(wren_cycles - wc), 32'd1);

      // Held key gives one write; a fresh press gives a second.
      sw_addr = 5'h07;
      sw_data = 4'h3;
      step(4);
      wc = wren_cycles;
      key_write = 1'b1;
      step(3);
      check("h_wren", 32'(wren), 32'h1);
      check("h_addr", 32'(address), 32'h07);
      step(97);
      key_write = 1'b0;
      step(5);
      check("h_count1", 32'(wren_cycles - wc), 32'd1);
      key_write = 1'b1;
      step(3);
      check("h_again", 32'(wren), 32'h1);
      key_write = 1'b0;
      step(5);
      check("h_count2", 32'(wren_cycles - wc), 32'd2);

      // Auto-scan with wrap; presses during scan are dropped.
      wc = wren_cycles;
      scan_mode = 1'b1;
      step(3);
      check("s_a0", 32'(address), 32'h0);
      step(4);
      check("s_a1", 32'(address), 32'h1);
      step(120);
      check("s_a31", 32'(address), 32'd31);
      step(4);
      check("s_wrap", 32'(address), 32'h0);
      key_write = 1'b1;
      step(6);
      key_write = 1'b0;
      step(6);
      scan_mode = 1'b0;
      step(5);
      check("s_nowr", 32'(wren_cycles - wc), 32'd0);
      check("s_exit", 32'(address), 32'h07);

      // Press coincident with scan request: write first, then scan from 0.
      sw_addr = 5'h1C;
      sw_data = 4'h5;
      step(4);
      key_write = 1'b1;
      scan_mode = 1'b1;
      step(3);
      check("ws_wren", 32'(wren), 32'h1);
      check("ws_addr", 32'(address), 32'h1C);
      step(1);
      check("ws_scan0", 32'(address), 32'h0);
      check("ws_wren0", 32'(wren), 32'h0);
      step(4);
      check("ws_scan1", 32'(address), 32'h1);
      key_write = 1'b0;
      scan_mode = 1'b0;
      step(5);
      check("ws_idle", 32'(address), 32'h1C);

      // Reset during a write cycle, key held through release.
      sw_addr = 5'h0B;
      sw_data = 4'h6;
      step(3);
      key_write = 1'b1;
      step(3);
      check("rw_wren", 32'(wren), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("rw_abort", 32'(wren), 32'h0);
      check("rw_addr", 32'(address), 32'h0);
      step(2);
      reset = 1'b0;
      wc = wren_cycles;
      step(10);
      check("rw_noedge", 32'(wren_cycles - wc), 32'd0);
      key_write = 1'b0;
      step(4);
      key_write = 1'b1;
      step(3);
      check("rw_press", 32'(wren), 32'h1);
      key_write = 1'b0;
      step(4);

`ifdef MEM_CLEAR_EN
      // Clear sequence; a write press during it adds nothing.
      sw_addr = 5'h15;
      step(2);
      wc = wren_cycles;
      key_clear = 1'b1;
      step(1);
      key_clear = 1'b0;
      step(2);
      check("c_busy", 32'(busy), 32'h1);
      check("c_wren", 32'(wren), 32'h1);
      check("c_addr0", 32'(address), 32'h0);
      key_write = 1'b1;
      step(5);
      key_write = 1'b0;
      step(2);
      check("c_addr7", 32'(address), 32'h7);
      step(25);
      check("c_done", 32'(busy), 32'h0);
      check("c_idle", 32'(address), 32'h15);
      step(4);
      check("c_count", 32'(wren_cycles - wc), 32'd32);

      // Clear wins over a simultaneous write press.
      wc = wren_cycles;
      key_clear = 1'b1;
      key_write = 1'b1;
      step(3);
      check("cw_busy", 32'(busy), 32'h1);
      key_clear = 1'b0;
      key_write = 1'b0;
      step(40);
      check("cw_count", 32'(wren_cycles - wc), 32'd32);

      // Reset at clear cycle 10.
      key_clear = 1'b1;
      step(1);
      key_clear = 1'b0;
      step(2);
      step(10);
      check("cr_addr10", 32'(address), 32'd10);
      #2 reset = 1'b1;
      #1;
      check("cr_wren", 32'(wren), 32'h0);
      check("cr_busy", 32'(busy), 32'h0);
      check("cr_addr", 32'(address), 32'h0);
      step(2);
      reset = 1'b0;
      step(6);
      check("cr_idle_busy", 32'(busy), 32'h0);
      check("cr_idle_addr", 32'(address), 32'h15);
`endif

      step(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
